mem_port_arbiter: RTL

- Shares the single unified memory port of the multicycle core between three requesters: 0 = instruction fetch, 1 = data load/store, 2 = debug/loader.
- Owns the memory-side handshake, tracks which requester owns the outstanding access, and routes the response back to it.
- Provides a wait-state timeout so a dead memory cannot hang the control FSM.
- Sits between the control/datapath and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [2:0]      req_valid;
    logic [2:0]      req_write;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]      req_ready;
    logic [2:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-requester arbiter for the unified memory port with wait-state timeout
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority data > ifetch > debug.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            win_any;
    logic [1:0]      win_idx;
    logic [AW-1:0]   addr_arr  [3];
    logic [DW-1:0]   wdata_arr [3];
    logic            timeout_hit;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_arr[i]  = bus.req_addr[i*AW +: AW];
            wdata_arr[i] = bus.req_wdata[i*DW +: DW];
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] rr_base;
    logic [2:0] rr_sum;
    logic [1:0] rr_cand;

    // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        rr_base = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
        rr_sum  = 3'd0;
        rr_cand = 2'd0;
        win_any = 1'b0;
        win_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            rr_sum  = {1'b0, rr_base} + 3'(k);
            rr_cand = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
            if (bus.req_valid[rr_cand]) begin
                win_any = 1'b1;
                win_idx = rr_cand;
            end
        end
    end
`else
    always_comb begin
        win_any = |bus.req_valid;
        if (bus.req_valid[1])      win_idx = 2'd1;
        else if (bus.req_valid[0]) win_idx = 2'd0;
        else                       win_idx = 2'd2;
    end
`endif

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    mem_we_d    = bus.req_write[win_idx];
                    mem_addr_d  = addr_arr[win_idx];
                    mem_wdata_d = wdata_arr[win_idx];
                    owner_d     = win_idx;
                    mem_req_d   = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = win_idx;
`endif
                end
            end
            BUSY: begin
                // A late ack in the timeout cycle still completes the access cleanly.
                if (bus.mem_ack) begin
                    rsp_rdata_d = bus.mem_rdata;
                    rsp_err_d   = 1'b0;
                    mem_req_d   = 1'b0;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 2'd2;
        else        last_grant_q <= last_grant_d;
    end
`endif

    assign bus.req_ready = (state_q == IDLE && win_any) ? (3'b001 << win_idx) : 3'b000;
    assign bus.rsp_valid = (state_q == RESP) ? (3'b001 << owner_q) : 3'b000;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
